dcache_arbiter: RTL and testbench
=================================

Name: dcache_arbiter

Overview:
- Shares the single-port 16-bit x 256-word data cache memory between two requesters: port 0 is the CPU load/store unit, port 1 is the debug/DMA port.
- Serialises accesses with a req/gnt handshake and drives the memory's r_en/w_en/addr/w_data strobes from registers.
- Captures the memory's one-cycle-latency r_data and returns it with a valid pulse.
- Sits between the core datapath and the dcache memory instance.

Parameters:
- DATA_W, 16, data width of requesters and memory.
- ADDR_W, 16, address width of requesters and memory.
- DEPTH, 256, number of implemented words; addresses >= DEPTH are out of range.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- m0_req / m1_req  in  1  access request; held with fields stable until gnt.
- m0_we / m1_we  in  1  1 = write, 0 = read.
- m0_addr / m1_addr  in  ADDR_W  word address.
- m0_wdata / m1_wdata  in  DATA_W  write data.
- m0_gnt / m1_gnt  out  1  one-cycle grant pulse; request consumed.
- m0_rvalid / m1_rvalid  out  1  one-cycle read-data-valid pulse.
- m0_rdata / m1_rdata  out  DATA_W  read data, valid when rvalid.
- m0_err / m1_err  out  1  one-cycle pulse, coincident with gnt, for an out-of-range address.
- mem_r_en  out  1  memory read strobe.
- mem_w_en  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_w_data  out  DATA_W  memory write data.
- mem_r_data  in  DATA_W  memory registered read data, valid the cycle after mem_r_en.

Behaviour:
- Reset:
  - Applies synchronously while reset=1, including mid-access.
  - State=IDLE; all gnt/rvalid/err/mem_r_en/mem_w_en = 0.
  - mem_addr, mem_w_data, rdata = 0; round-robin pointer = port 0.
  - An in-flight access is dropped: no gnt and no rvalid are produced for it.
- FSM states: IDLE, ACCESS, RDWAIT, RESP.
- IDLE:
  - If any req=1, pick a winner, latch its we/addr/wdata and register the strobes.
  - Strobe rule: mem_r_en = ~we, mem_w_en = we, each suppressed if addr >= DEPTH.
  - Go to ACCESS.
  - If neither req=1, stay in IDLE with strobes 0.
- ACCESS (cycle N+1 after request sampled in N):
  - Strobes high for exactly this cycle; winner's gnt=1.
  - err=1 with gnt if addr >= DEPTH.
  - Next state: write -> IDLE; in-range read -> RDWAIT; out-of-range read -> RESP with rdata forced to 0.
- RDWAIT: strobes 0; mem_r_data sampled into the winner's rdata at the end of this cycle; -> RESP.
- RESP: winner's rvalid=1 for one cycle with rdata stable; -> IDLE.
- Timing:
  - Write: req cycle N, gnt N+1, next arbitration N+2.
  - Read: gnt N+1, rvalid N+3, next arbitration N+4.
  - Back-to-back reads sustain one access per 4 cycles.
- The non-winning rdata is held unchanged.
- Requester rules: the requester deasserts req, or presents a new request, on the edge after gnt. The arbiter ignores req outside IDLE.
- Arbitration: fixed priority, port 0 wins a simultaneous request; port 1 waits while port 0 keeps requesting.
- Write and read to the same address from different ports are strictly ordered by grant order.
- The memory never sees r_en and w_en high together.

Optional Feature:
- Macro: DCACHE_ARB_RR_EN.
- Defined: round-robin. A 1-bit pointer names the preferred port; on each grant the pointer moves to the other port. On a simultaneous request the preferred port wins.
- Undefined: fixed priority, port 0 always wins; the pointer logic is not synthesised.

Decomposition:
- Package dcache_arb_pkg holds:
  - state enum (IDLE, ACCESS, RDWAIT, RESP);
  - DCACHE_DATA_W = 16, DCACHE_ADDR_W = 16, DCACHE_DEPTH = 256;
  - port-index constants PORT_CPU = 0, PORT_DBG = 1.
- One sub-module is natural: dcache_arb_pick.
  - Combinational two-way picker.
  - Inputs: req vector, pointer, rr mode. Output: winner index and any-valid.
  - Reused by later bus arbiters.

Test Plan:
- Reset 3 cycles, then idle: all outputs 0; mem strobes never assert.
- m0 write addr 16'h0010, data 16'hBEEF; then m0 read 16'h0010:
  - gnt at N+1, mem_w_en pulse one cycle;
  - read rvalid at N+3 with rdata = 16'hBEEF.
- m0 and m1 both read (0x0001, 0x0002) in the same cycle, fixed priority: m0 granted first; m1 gnt 4 cycles later.
  - With DCACHE_ARB_RR_EN and both requests held: grants alternate m0, m1, m0, m1.
- m1 read addr 16'h0100 (out of range): gnt and err pulse together; no mem strobe; rvalid 2 cycles later with rdata 16'h0000.
- Assert reset in RDWAIT of an m0 read: no rvalid follows; FSM in IDLE on the cycle after reset releases; the next request is served normally.
- Random stress, 10k cycles, against a scoreboard model:
  - never r_en and w_en together;
  - exactly one gnt per accepted request;
  - read data matches the model.

Source files
------------

// File: rtl/dcache_arb_pkg.sv
// Shared types and constants for the dcache arbiter slice.
// Defining DCACHE_ARB_RR_EN switches the arbiter to round-robin.
package dcache_arb_pkg;

  localparam int DCACHE_DATA_W = 16;
  localparam int DCACHE_ADDR_W = 16;
  localparam int DCACHE_DEPTH  = 256;

  localparam int PORT_CPU = 0;
  localparam int PORT_DBG = 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RDWAIT,
    RESP
  } arb_state_e;

endpackage

// File: rtl/dcache_arbiter_if.sv
// Requester and memory signals of the dcache arbiter.
// slave = arbiter view; master = requesters plus memory.
interface dcache_arbiter_if #(
  parameter int DATA_W = dcache_arb_pkg::DCACHE_DATA_W,
  parameter int ADDR_W = dcache_arb_pkg::DCACHE_ADDR_W
);
  logic              m0_req, m0_we, m0_gnt, m0_rvalid, m0_err;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata, m0_rdata;
  logic              m1_req, m1_we, m1_gnt, m1_rvalid, m1_err;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata, m1_rdata;
  logic              mem_r_en, mem_w_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_w_data, mem_r_data;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  mem_r_data,
    output m0_gnt, m0_rvalid, m0_rdata, m0_err,
    output m1_gnt, m1_rvalid, m1_rdata, m1_err,
    output mem_r_en, mem_w_en, mem_addr, mem_w_data
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output mem_r_data,
    input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
    input  m1_gnt, m1_rvalid, m1_rdata, m1_err,
    input  mem_r_en, mem_w_en, mem_addr, mem_w_data
  );
endinterface

// File: rtl/dcache_arb_pick.sv
// Combinational two-way picker: a lone requester always wins; on a tie the
// pointer decides in rr mode, otherwise port 0 wins.
module dcache_arb_pick (
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       rr_en,
  output logic       win,
  output logic       any
);
  always_comb begin
    any = |req;
    win = 1'b0;
    if (&req) win = rr_en ? ptr : 1'b0;
    else      win = req[1];
  end
endmodule

// File: rtl/dcache_arbiter.sv
// Two-port arbiter for the single-port dcache memory with registered strobes.
// Build with DCACHE_ARB_RR_EN for round-robin, otherwise fixed priority.
module dcache_arbiter
  import dcache_arb_pkg::*;
#(
  parameter int DATA_W = DCACHE_DATA_W,
  parameter int ADDR_W = DCACHE_ADDR_W,
  parameter int DEPTH  = DCACHE_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  dcache_arbiter_if.slave  bus
);
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  logic [1:0]             req, we_v, gnt, rvalid, err;
  logic [1:0][ADDR_W-1:0] addr_v;
  logic [1:0][DATA_W-1:0] wdata_v, rdata_q;

  arb_state_e        state_q, state_nx;
  logic              win, any, win_q, we_q, oor_q;
  logic              r_en_q, w_en_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              sel_we, sel_oor;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              rr_ptr, rr_en;

  assign req     = {bus.m1_req,   bus.m0_req};
  assign we_v    = {bus.m1_we,    bus.m0_we};
  assign addr_v  = {bus.m1_addr,  bus.m0_addr};
  assign wdata_v = {bus.m1_wdata, bus.m0_wdata};

  dcache_arb_pick u_pick (
    .req   (req),
    .ptr   (rr_ptr),
    .rr_en (rr_en),
    .win   (win),
    .any   (any)
  );

  assign sel_we    = we_v[win];
  assign sel_addr  = addr_v[win];
  assign sel_wdata = wdata_v[win];
  assign sel_oor   = 32'(sel_addr) >= DEPTH_U;

`ifdef DCACHE_ARB_RR_EN
  // Pointer hands preference to the port that did not just win.
  assign rr_en = 1'b1;
  always_ff @(posedge clk) begin
    if (reset)                 rr_ptr <= 1'(PORT_CPU);
    else if (state_q == ACCESS) rr_ptr <= ~win_q;
  end
`else
  assign rr_en  = 1'b0;
  assign rr_ptr = 1'(PORT_CPU);
`endif

  always_comb begin
    state_nx = state_q;
    case (state_q)
      IDLE:    if (any) state_nx = ACCESS;
      ACCESS:  begin
        if (we_q)       state_nx = IDLE;
        else if (oor_q) state_nx = RESP;
        else            state_nx = RDWAIT;
      end
      RDWAIT:  state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      win_q   <= 1'b0;
      we_q    <= 1'b0;
      oor_q   <= 1'b0;
      r_en_q  <= 1'b0;
      w_en_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_nx;
      r_en_q  <= 1'b0;
      w_en_q  <= 1'b0;
      // Strobes are registered here so they are high only during ACCESS.
      if (state_q == IDLE && any) begin
        win_q   <= win;
        we_q    <= sel_we;
        oor_q   <= sel_oor;
        r_en_q  <= ~sel_we & ~sel_oor;
        w_en_q  <= sel_we & ~sel_oor;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
      end
      if (state_q == ACCESS && !we_q && oor_q) rdata_q[win_q] <= '0;
      if (state_q == RDWAIT)                   rdata_q[win_q] <= bus.mem_r_data;
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_port
    assign gnt[i]    = (state_q == ACCESS) && (win_q == 1'(i));
    assign err[i]    = gnt[i] && oor_q;
    assign rvalid[i] = (state_q == RESP) && (win_q == 1'(i));
  end

  assign bus.m0_gnt    = gnt[PORT_CPU];
  assign bus.m0_err    = err[PORT_CPU];
  assign bus.m0_rvalid = rvalid[PORT_CPU];
  assign bus.m0_rdata  = rdata_q[PORT_CPU];
  assign bus.m1_gnt    = gnt[PORT_DBG];
  assign bus.m1_err    = err[PORT_DBG];
  assign bus.m1_rvalid = rvalid[PORT_DBG];
  assign bus.m1_rdata  = rdata_q[PORT_DBG];

  assign bus.mem_r_en   = r_en_q;
  assign bus.mem_w_en   = w_en_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_w_data = wdata_q;
endmodule

// File: tb/tb_dcache_arbiter.sv
// Directed and random checks of dcache_arbiter against a 256-word memory model.
// Round-robin expectations apply when DCACHE_ARB_RR_EN is defined.
module tb_dcache_arbiter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dcache_arbiter_if bus ();
  dcache_arbiter dut (.clk(clk), .reset(reset), .bus(bus));

  // Memory model: registered read data, one-cycle latency, no reset.
  logic [15:0] mem [0:255];
  always_ff @(posedge clk) begin
    if (bus.mem_w_en) mem[bus.mem_addr[7:0]] <= bus.mem_w_data;
    if (bus.mem_r_en) bus.mem_r_data <= mem[bus.mem_addr[7:0]];
  end

  int n_run = 0, n_fail = 0;
  logic [15:0] sb_mem [0:255];
  logic        g [2], e [2], rv [2];
  logic [15:0] rd [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    g[0] = bus.m0_gnt;    g[1] = bus.m1_gnt;
    e[0] = bus.m0_err;    e[1] = bus.m1_err;
    rv[0] = bus.m0_rvalid; rv[1] = bus.m1_rvalid;
    rd[0] = bus.m0_rdata; rd[1] = bus.m1_rdata;
  endtask

  task automatic drv(input int p, input logic r, input logic w,
                     input logic [15:0] a, input logic [15:0] d);
    if (p == 0) begin
      bus.m0_req = r; bus.m0_we = w; bus.m0_addr = a; bus.m0_wdata = d;
    end else begin
      bus.m1_req = r; bus.m1_we = w; bus.m1_addr = a; bus.m1_wdata = d;
    end
  endtask

  function automatic logic [7:0] outs();
    return {bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid,
            bus.m0_err, bus.m1_err, bus.mem_r_en, bus.mem_w_en};
  endfunction

  // stress bookkeeping
  logic        pend [2], pwe [2], rd_pend [2];
  logic [15:0] paddr [2], pwd [2], exp_rd [2];
  int issued [2], ngnt [2];
  int viol = 0, bad_gnt = 0, bad_rv = 0, rd_bad = 0, err_bad = 0, nreads = 0;

  initial begin
    int f, s, k;
    int seq [4];
    int exp_seq [4];
    logic [15:0] a;
    reset = 1'b1;
    drv(0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0);

    // reset and idle
    repeat (3) tick();
    chk("rst_outs", outs(), 0);
    reset = 1'b0;
    repeat (2) tick();
    chk("idle_outs", outs(), 0);
    chk("idle_addr", bus.mem_addr, 0);
    chk("idle_rdata", {bus.m0_rdata, bus.m1_rdata}, 0);

    // fill memory through port 0 with addr ^ 5A5A
    for (int i = 0; i < 256; i++) begin
      drv(0, 1, 1, 16'(i), 16'(i) ^ 16'h5A5A);
      sb_mem[i] = 16'(i) ^ 16'h5A5A;
      tick();
      drv(0, 0, 0, 0, 0);
      tick();
    end

    // write 0x0010 = BEEF, then read it back
    drv(0, 1, 1, 16'h0010, 16'hBEEF);
    tick();
    chk("w_gnt", bus.m0_gnt, 1);
    chk("w_wen", bus.mem_w_en, 1);
    chk("w_ren", bus.mem_r_en, 0);
    chk("w_addr", bus.mem_addr, 16'h0010);
    chk("w_data", bus.mem_w_data, 16'hBEEF);
    chk("w_err", bus.m0_err, 0);
    sb_mem[16] = 16'hBEEF;
    drv(0, 1, 0, 16'h0010, 0);
    tick();
    chk("w_pulse", {bus.m0_gnt, bus.mem_w_en}, 0);
    tick();
    chk("r_gnt", bus.m0_gnt, 1);
    chk("r_ren", bus.mem_r_en, 1);
    drv(0, 0, 0, 0, 0);
    tick();
    chk("r_wait", {bus.m0_rvalid, bus.mem_r_en}, 0);
    tick();
    chk("r_rvalid", bus.m0_rvalid, 1);
    chk("r_rdata", bus.m0_rdata, 16'hBEEF);
    tick();
    chk("r_rv_pulse", bus.m0_rvalid, 0);
    chk("r_rdata_hold", bus.m0_rdata, 16'hBEEF);

    // simultaneous reads; the pointer favours port 1 here in rr mode
`ifdef DCACHE_ARB_RR_EN
    f = 1; s = 0;
`else
    f = 0; s = 1;
`endif
    drv(0, 1, 0, 16'h0001, 0);
    drv(1, 1, 0, 16'h0002, 0);
    tick(); smp();
    chk("tie_first", {g[f], g[s]}, 2'b10);
    drv(f, 0, 0, 0, 0);
    tick(); tick(); smp();
    chk("tie_first_rv", rv[f], 1);
    chk("tie_first_rd", rd[f], f == 0 ? 16'h5A5B : 16'h5A58);
    tick(); smp();
    chk("tie_second_wait", g[s], 0);
    tick(); smp();
    chk("tie_second_gnt", g[s], 1);
    drv(s, 0, 0, 0, 0);
    tick(); tick(); smp();
    chk("tie_second_rd", rd[s], s == 0 ? 16'h5A5B : 16'h5A58);
    chk("tie_hold_other", rd[f], f == 0 ? 16'h5A5B : 16'h5A58);
    tick();

    // both requests held: fixed priority starves port 1, rr alternates
`ifdef DCACHE_ARB_RR_EN
    exp_seq = '{1, 0, 1, 0};
`else
    exp_seq = '{0, 0, 0, 0};
`endif
    drv(0, 1, 0, 16'h0001, 0);
    drv(1, 1, 0, 16'h0002, 0);
    k = 0;
    for (int c = 0; c < 40 && k < 4; c++) begin
      tick(); smp();
      if (g[0] || g[1]) begin
        seq[k] = g[1] ? 1 : 0;
        k++;
      end
    end
    drv(0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0);
    chk("hold_cnt", k, 4);
    for (int i = 0; i < 4 && i < k; i++) chk("hold_seq", seq[i], exp_seq[i]);
    repeat (4) tick();

    // out-of-range read on port 1
    drv(1, 1, 0, 16'h0100, 0);
    tick();
    chk("oor_gnt_err", {bus.m1_gnt, bus.m1_err, bus.m0_gnt}, 3'b110);
    chk("oor_strobes", {bus.mem_r_en, bus.mem_w_en}, 0);
    drv(1, 0, 0, 0, 0);
    tick();
    chk("oor_rvalid", bus.m1_rvalid, 1);
    chk("oor_rdata", bus.m1_rdata, 0);
    tick();
    chk("oor_rv_pulse", bus.m1_rvalid, 0);

    // last in-range word, then an aliasing out-of-range write must not land
    drv(0, 1, 1, 16'h00FF, 16'h1234);
    tick();
    chk("ff_w", {bus.m0_gnt, bus.m0_err, bus.mem_w_en}, 3'b101);
    sb_mem[255] = 16'h1234;
    drv(0, 1, 1, 16'hFFFF, 16'hDEAD);
    tick(); tick();
    chk("oor_w", {bus.m0_gnt, bus.m0_err, bus.mem_w_en}, 3'b110);
    drv(0, 1, 0, 16'h00FF, 0);
    tick(); tick();
    chk("ff_r_gnt", {bus.m0_gnt, bus.m0_err, bus.mem_r_en}, 3'b101);
    drv(0, 0, 0, 0, 0);
    tick(); tick();
    chk("ff_r_data", {bus.m0_rvalid, bus.m0_rdata}, {1'b1, 16'h1234});
    tick();

    // reset during RDWAIT drops the read
    drv(0, 1, 0, 16'h0010, 0);
    tick();
    chk("rst_rd_gnt", bus.m0_gnt, 1);
    drv(0, 0, 0, 0, 0);
    tick();
    reset = 1'b1;
    tick();
    chk("rst_mid_outs", outs(), 0);
    reset = 1'b0;
    tick();
    chk("rst_no_rv", bus.m0_rvalid, 0);
    chk("rst_rdata", bus.m0_rdata, 0);
    drv(0, 1, 0, 16'h0010, 0);
    tick();
    chk("post_rst_gnt", bus.m0_gnt, 1);
    drv(0, 0, 0, 0, 0);
    tick(); tick();
    chk("post_rst_rd", {bus.m0_rvalid, bus.m0_rdata}, {1'b1, 16'hBEEF});
    tick();

    // random stress against the scoreboard
    for (int p = 0; p < 2; p++) begin
      pend[p] = 0; rd_pend[p] = 0; issued[p] = 0; ngnt[p] = 0;
    end
    for (int c = 0; c < 10200; c++) begin
      tick(); smp();
      if (bus.mem_r_en && bus.mem_w_en) viol++;
      for (int p = 0; p < 2; p++) begin
        if (g[p]) begin
          if (!pend[p]) bad_gnt++;
          else begin
            ngnt[p]++;
            if (e[p] != (paddr[p] >= 16'd256)) err_bad++;
            if (pwe[p]) begin
              if (paddr[p] < 16'd256) sb_mem[paddr[p][7:0]] = pwd[p];
            end else begin
              exp_rd[p] = (paddr[p] < 16'd256) ? sb_mem[paddr[p][7:0]] : 16'h0000;
              rd_pend[p] = 1;
            end
            pend[p] = 0;
            drv(p, 0, 0, 0, 0);
          end
        end
        if (rv[p]) begin
          if (!rd_pend[p]) bad_rv++;
          else begin
            nreads++;
            if (rd[p] != exp_rd[p]) rd_bad++;
          end
          rd_pend[p] = 0;
        end
        if (c < 10000 && !pend[p] && $urandom_range(0, 3) == 0) begin
          a = ($urandom_range(0, 9) == 0) ? 16'(16'h0100 + $urandom_range(0, 16'hFEFF))
                                          : 16'($urandom_range(0, 255));
          pwe[p] = 1'($urandom_range(0, 1));
          paddr[p] = a;
          pwd[p] = 16'($urandom);
          pend[p] = 1;
          issued[p]++;
          drv(p, 1, pwe[p], a, pwd[p]);
        end
      end
    end
    chk("st_drained", {pend[0], pend[1], rd_pend[0], rd_pend[1]}, 0);
    chk("st_gnt0", ngnt[0], issued[0]);
    chk("st_gnt1", ngnt[1], issued[1]);
    chk("st_rw_excl", viol, 0);
    chk("st_bad_gnt", bad_gnt, 0);
    chk("st_bad_rv", bad_rv, 0);
    chk("st_err", err_bad, 0);
    chk("st_rdata", rd_bad, 0);
    chk("st_reads_seen", nreads > 100, 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
